move_sequencer: RTL and testbench
=================================

// Module: move_sequencer
// PURPOSE
//  Sequences one chess move into the 8x8 board register file: accepts a src/dst request, reads both squares,
//  applies basic legality screening (ownership/turn only, no piece-movement rules), then issues remove@src,
//  place@dst. Tracks side to move and reports captures and rejects. Sits between input/UI logic and the board.
// PARAMETERS
//  CODE_W  4  piece code width (0 empty, 1-6 white P,B,N,R,Q,K, 7-C black P,B,N,R,Q,K, D-F invalid)
//  POS_W   6  square index width: [2:0] column, [5:3] row; row 0 = black back rank, row 7 = white back rank
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  move_valid   in   1       move request present
//  move_ready   out  1       sequencer can accept (state IDLE)
//  move_src     in   POS_W   source square
//  move_dst     in   POS_W   destination square
//  rd_pos       out  POS_W   board read address
//  rd_code      in   CODE_W  board contents at rd_pos (combinational from board)
//  wr_pos       out  POS_W   board write address
//  wr_code      out  CODE_W  code to place
//  wr_place     out  1       place strobe (board writes wr_code at wr_pos next edge)
//  wr_remove    out  1       remove strobe (board writes 0 at wr_pos next edge)
//  turn         out  1       side to move: 0 white, 1 black
//  busy         out  1       ~move_ready
//  done         out  1       1-cycle pulse, move committed
//  reject       out  1       1-cycle pulse, move refused; board untouched
//  reject_code  out  3       0 none,1 src==dst,2 src empty/invalid,3 src not side-to-move,4 dst own piece/invalid
//  capture      out  1       valid with done: dst held opponent piece
//  captured     out  CODE_W  valid with done: code removed from dst (0 if none)
// BEHAVIOUR
//  Reset: state IDLE, turn=0, all strobes/pulses 0, rd_pos=wr_pos=0, wr_code=0, reject_code=0, captured=0.
//  FSM: IDLE -> RD_SRC -> RD_DST -> CHECK -> {REMOVE -> PLACE -> DONE | REJECT} -> IDLE.
//  IDLE: move_ready=1; on move_valid latch src/dst, rd_pos<=src. Request accepted only in IDLE; ignored otherwise.
//  RD_SRC: src_code<=rd_code, rd_pos<=dst. RD_DST: dst_code<=rd_code.
//  CHECK: first failing rule in order 1..4 sets reject_code -> REJECT; else -> REMOVE.
//  REMOVE: wr_remove=1, wr_pos=src. PLACE: wr_place=1, wr_pos=dst, wr_code=src_code (see CONFIGURATION).
//  DONE: done=1, capture/captured valid, turn toggles at exit. REJECT: reject=1 with reject_code; turn unchanged.
//  Strobes decoded from state register only; never place and remove in same cycle.
//  Latency accept->done pulse: 6 cycles; accept->reject pulse: 4 cycles; back-to-back gap min 1 IDLE cycle.
//  Capture of opponent king is committed like any capture (game-end detection out of scope).
//  reject_code/captured hold until next CHECK; done/reject are single-cycle.
//  rst mid-move: immediate IDLE, turn=0, strobes drop same instant; partial move discarded (board resets too).
// CONFIGURATION
//  PROMOTION_EN defined: in PLACE, white pawn (1) to row 0 writes 5; black pawn (7) to row 7 writes B.
//  PROMOTION_EN undefined: pawn written unchanged on every row.
// STRUCTURE
//  chess_pkg: piece code localparams, state_t enum, reject_t enum, functions is_white/is_black/is_empty/is_valid.
//  Sub-module move_screen (combinational): src/dst codes, positions, turn -> ok, reject_code, capture.
// TESTING
//  Reset, move 6,4->4,4 (W pawn e2-e4) -> remove@52, place@36 code 1, done at +6, turn=1, capture=0.
//  turn=0, move src=52 dst=52 -> reject at +4, code 1, no strobes, turn stays 0.
//  turn=0, src=40 (empty) -> reject code 2; src=8 (black pawn) -> reject code 3.
//  turn=0, src=63 (W rook) dst=62 (W knight) -> reject code 4, board unchanged.
//  Preload dst=20 code 9, W bishop src moves there -> done, capture=1, captured=9, wr_code=2.
//  PROMOTION_EN: W pawn src=8 dst=0 -> wr_code=5; undefined -> wr_code=1. rst during PLACE -> strobes 0, turn 0.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared piece encoding, FSM state and reject-reason types for the move sequencer.
// Piece codes: 0 empty, 1-6 white P,B,N,R,Q,K, 7-C black P,B,N,R,Q,K, D-F invalid.
package chess_pkg;

    localparam int PIECE_W = 4;
    localparam int SQ_W    = 6;

    localparam logic [PIECE_W-1:0] EMPTY    = 4'h0;
    localparam logic [PIECE_W-1:0] W_PAWN   = 4'h1;
    localparam logic [PIECE_W-1:0] W_QUEEN  = 4'h5;
    localparam logic [PIECE_W-1:0] W_KING   = 4'h6;
    localparam logic [PIECE_W-1:0] B_PAWN   = 4'h7;
    localparam logic [PIECE_W-1:0] B_QUEEN  = 4'hB;
    localparam logic [PIECE_W-1:0] B_KING   = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DST,
        S_CHECK,
        S_REMOVE,
        S_PLACE,
        S_DONE,
        S_REJECT
    } state_t;

    typedef enum logic [2:0] {
        RJ_NONE      = 3'd0,
        RJ_SAME_SQ   = 3'd1,
        RJ_SRC_EMPTY = 3'd2,
        RJ_NOT_TURN  = 3'd3,
        RJ_DST_OWN   = 3'd4
    } reject_t;

    function automatic logic is_empty(input logic [PIECE_W-1:0] code);
        return code == EMPTY;
    endfunction

    function automatic logic is_white(input logic [PIECE_W-1:0] code);
        return (code >= W_PAWN) && (code <= W_KING);
    endfunction

    function automatic logic is_black(input logic [PIECE_W-1:0] code);
        return (code >= B_PAWN) && (code <= B_KING);
    endfunction

    // Empty counts as valid; only D-F are garbage.
    function automatic logic is_valid(input logic [PIECE_W-1:0] code);
        return code <= B_KING;
    endfunction

endpackage

// File: rtl/move_screen.sv
// Combinational legality screen: ownership and side-to-move checks only, first failing
// rule wins (same square, source empty/invalid, source not ours, destination ours/invalid).
module move_screen
    import chess_pkg::*;
#(
    parameter int CODE_W = PIECE_W,
    parameter int POS_W  = SQ_W
) (
    input  logic [CODE_W-1:0] src_code,
    input  logic [CODE_W-1:0] dst_code,
    input  logic [POS_W-1:0]  src_pos,
    input  logic [POS_W-1:0]  dst_pos,
    input  logic              turn,
    output logic              ok,
    output logic [2:0]        reject_code,
    output logic              capture
);

    reject_t rc;
    logic    src_ours;
    logic    dst_ours;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rc       = RJ_NONE;
        src_ours = turn ? is_black(src_code) : is_white(src_code);
        dst_ours = turn ? is_black(dst_code) : is_white(dst_code);
        capture  = turn ? is_white(dst_code) : is_black(dst_code);

        if (src_pos == dst_pos)
            rc = RJ_SAME_SQ;
        else if (is_empty(src_code) || !is_valid(src_code))
            rc = RJ_SRC_EMPTY;
        else if (!src_ours)
            rc = RJ_NOT_TURN;
        else if (dst_ours || !is_valid(dst_code))
            rc = RJ_DST_OWN;
    end

    assign ok          = (rc == RJ_NONE);
    assign reject_code = rc;

endmodule

// File: rtl/move_sequencer.sv
// Sequences one move into the board register file: read src, read dst, screen, remove@src, place@dst.
// Optional feature: define PROMOTION_EN to turn a pawn reaching the far rank into a queen.
module move_sequencer
    import chess_pkg::*;
#(
    parameter int CODE_W = PIECE_W,
    parameter int POS_W  = SQ_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [POS_W-1:0]  move_src,
    input  logic [POS_W-1:0]  move_dst,
    output logic [POS_W-1:0]  rd_pos,
    input  logic [CODE_W-1:0] rd_code,
    output logic [POS_W-1:0]  wr_pos,
    output logic [CODE_W-1:0] wr_code,
    output logic              wr_place,
    output logic              wr_remove,
    output logic              turn,
    output logic              busy,
    output logic              done,
    output logic              reject,
    output logic [2:0]        reject_code,
    output logic              capture,
    output logic [CODE_W-1:0] captured
);

    state_t            state_q, state_d;
    logic [POS_W-1:0]  src_pos, dst_pos;
    logic [CODE_W-1:0] src_code, dst_code;
    logic [CODE_W-1:0] place_code;
    logic              scr_ok, scr_capture;
    logic [2:0]        scr_rc;

    move_screen #(.CODE_W(CODE_W), .POS_W(POS_W)) u_screen (
        .src_code    (src_code),
        .dst_code    (dst_code),
        .src_pos     (src_pos),
        .dst_pos     (dst_pos),
        .turn        (turn),
        .ok          (scr_ok),
        .reject_code (scr_rc),
        .capture     (scr_capture)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_pos     <= '0;
            dst_pos     <= '0;
            src_code    <= '0;
            dst_code    <= '0;
            rd_pos      <= '0;
            turn        <= 1'b0;
            reject_code <= '0;
            capture     <= 1'b0;
            captured    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (move_valid) begin
                    src_pos <= move_src;
                    dst_pos <= move_dst;
                    rd_pos  <= move_src;
                end
                S_RD_SRC: begin
                    src_code <= rd_code;
                    rd_pos   <= dst_pos;
                end
                S_RD_DST: dst_code <= rd_code;
                S_CHECK: begin
                    reject_code <= scr_rc;
                    capture     <= scr_ok && scr_capture;
                    captured    <= (scr_ok && scr_capture) ? dst_code : '0;
                end
                S_DONE:  turn <= ~turn;
                default: ;
            endcase
        end
    end

    always_comb begin
        place_code = src_code;
`ifdef PROMOTION_EN
        if (src_code == W_PAWN && dst_pos[POS_W-1:POS_W-3] == 3'd0)
            place_code = W_QUEEN;
        else if (src_code == B_PAWN && dst_pos[POS_W-1:POS_W-3] == 3'd7)
            place_code = B_QUEEN;
`endif
    end

    // Strobes decode from state_q alone, so an async reset drops them immediately.
    always_comb begin
        state_d    = state_q;
        move_ready = 1'b0;
        done       = 1'b0;
        reject     = 1'b0;
        wr_place   = 1'b0;
        wr_remove  = 1'b0;
        wr_pos     = '0;
        wr_code    = '0;
        case (state_q)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid)
                    state_d = S_RD_SRC;
            end
            S_RD_SRC: state_d = S_RD_DST;
            S_RD_DST: state_d = S_CHECK;
            S_CHECK:  state_d = scr_ok ? S_REMOVE : S_REJECT;
            S_REMOVE: begin
                wr_remove = 1'b1;
                wr_pos    = src_pos;
                state_d   = S_PLACE;
            end
            S_PLACE: begin
                wr_place = 1'b1;
                wr_pos   = dst_pos;
                wr_code  = place_code;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_REJECT: begin
                reject  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = ~move_ready;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: board model, table of moves with expectations queued per request.
// Honours PROMOTION_EN for the pawn-promotion expectation.
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] move_src, move_dst;
    logic [5:0] rd_pos;
    logic [3:0] rd_code;
    logic [5:0] wr_pos;
    logic [3:0] wr_code;
    logic       wr_place, wr_remove;
    logic       turn, busy, done, reject;
    logic [2:0] reject_code;
    logic       capture;
    logic [3:0] captured;

    logic [3:0] board [64];
    logic       pre_en;
    logic [5:0] pre_pos;
    logic [3:0] pre_code;

    int checks = 0;
    int errors = 0;

`ifdef PROMOTION_EN
    localparam logic [3:0] PROMO_W = 4'h5;
`else
    localparam logic [3:0] PROMO_W = 4'h1;
`endif

    typedef struct {
        logic [5:0] src;
        logic [5:0] dst;
        bit         pre_en;
        logic [5:0] pre_pos;
        logic [3:0] pre_code;
        bit         exp_done;
        logic [2:0] exp_rc;
        bit         exp_cap;
        logic [3:0] exp_captured;
        logic [3:0] exp_code;
        bit         exp_turn;
    } vec_t;

    vec_t vecs [9];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    move_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_src    (move_src),
        .move_dst    (move_dst),
        .rd_pos      (rd_pos),
        .rd_code     (rd_code),
        .wr_pos      (wr_pos),
        .wr_code     (wr_code),
        .wr_place    (wr_place),
        .wr_remove   (wr_remove),
        .turn        (turn),
        .busy        (busy),
        .done        (done),
        .reject      (reject),
        .reject_code (reject_code),
        .capture     (capture),
        .captured    (captured)
    );

    assign rd_code = board[rd_pos];

    // Board register file: standard opening position on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) board[i] <= 4'h0;
            for (int c = 0; c < 8; c++) begin
                board[8 + c]  <= 4'h7;
                board[48 + c] <= 4'h1;
            end
            board[0] <= 4'hA; board[1] <= 4'h9; board[2] <= 4'h8; board[3] <= 4'hB;
            board[4] <= 4'hC; board[5] <= 4'h8; board[6] <= 4'h9; board[7] <= 4'hA;
            board[56] <= 4'h4; board[57] <= 4'h3; board[58] <= 4'h2; board[59] <= 4'h5;
            board[60] <= 4'h6; board[61] <= 4'h2; board[62] <= 4'h3; board[63] <= 4'h4;
        end else begin
            if (wr_remove)     board[wr_pos] <= 4'h0;
            else if (wr_place) board[wr_pos] <= wr_code;
            if (pre_en)        board[pre_pos] <= pre_code;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] pos, input logic [3:0] code);
        @(negedge clk);
        pre_en = 1'b1; pre_pos = pos; pre_code = code;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run_move(input vec_t v);
        vec_t       e;
        logic [3:0] src_before, dst_before;
        int         k, end_k, rm_cnt, pl_cnt, overlap, wait_n;
        logic [5:0] rm_pos, pl_pos;
        logic [3:0] pl_code;
        logic       got_done, got_cap;
        logic [2:0] got_rc;
        logic [3:0] got_captured;

        if (v.pre_en) preload(v.pre_pos, v.pre_code);
        @(negedge clk);
        wait_n = 0;
        while (!move_ready && wait_n < 8) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_move", move_ready, 1'b1);

        src_before = board[v.src];
        dst_before = board[v.dst];
        exp_q.push_back(v);
        move_valid = 1'b1; move_src = v.src; move_dst = v.dst;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;

        k = 1; end_k = 0; rm_cnt = 0; pl_cnt = 0; overlap = 0;
        rm_pos = '0; pl_pos = '0; pl_code = '0;
        got_done = 1'b0; got_cap = 1'b0; got_rc = '0; got_captured = '0;
        while (end_k == 0 && k <= 12) begin
            if (wr_remove) begin rm_cnt++; rm_pos = wr_pos; end
            if (wr_place)  begin pl_cnt++; pl_pos = wr_pos; pl_code = wr_code; end
            if (wr_remove && wr_place) overlap++;
            if (done || reject) begin
                end_k = k; got_done = done; got_rc = reject_code;
                got_cap = capture; got_captured = captured;
            end else begin
                @(negedge clk);
                k++;
            end
        end

        if (end_k == 0) begin
            check("move_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
            return;
        end
        e = exp_q.pop_front();

        check("done_vs_reject", got_done, e.exp_done);
        check("reject_code", got_rc, e.exp_rc);
        if (e.exp_done) begin
            check("done_latency", end_k, 6);
            check("remove_count", rm_cnt, 1);
            check("place_count", pl_cnt, 1);
            check("remove_pos", rm_pos, e.src);
            check("place_pos", pl_pos, e.dst);
            check("place_code", pl_code, e.exp_code);
            check("strobe_overlap", overlap, 0);
            check("capture", got_cap, e.exp_cap);
            check("captured", got_captured, e.exp_captured);
        end else begin
            check("reject_latency", end_k, 4);
            check("reject_strobes", rm_cnt + pl_cnt, 0);
        end
        @(negedge clk);
        check("turn_after", turn, e.exp_turn);
        if (e.exp_done) begin
            check("board_src_cleared", board[e.src], 4'h0);
            check("board_dst_written", board[e.dst], e.exp_code);
        end else begin
            check("board_src_kept", board[e.src], src_before);
            check("board_dst_kept", board[e.dst], dst_before);
        end
    endtask

    task automatic reset_during_place(input logic [5:0] src, input logic [5:0] dst);
        int n;
        @(negedge clk);
        move_valid = 1'b1; move_src = src; move_dst = dst;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        n = 0;
        while (!wr_place && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reached_place", wr_place, 1'b1);
        check("turn_before_rst", turn, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_place_drop", wr_place, 1'b0);
        check("rst_remove_drop", wr_remove, 1'b0);
        check("rst_turn", turn, 1'b0);
        check("rst_ready", move_ready, 1'b1);
        check("rst_wr_code", wr_code, 4'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //          src    dst    pre   pre_pos pre_code done rc    cap   captd  code     turn
        vecs[0] = '{6'd52, 6'd36, 1'b0, 6'd0,  4'h0,    1'b1, 3'd0, 1'b0, 4'h0,  4'h1,    1'b1};
        vecs[1] = '{6'd12, 6'd28, 1'b0, 6'd0,  4'h0,    1'b1, 3'd0, 1'b0, 4'h0,  4'h7,    1'b0};
        vecs[2] = '{6'd52, 6'd52, 1'b0, 6'd0,  4'h0,    1'b0, 3'd1, 1'b0, 4'h0,  4'h0,    1'b0};
        vecs[3] = '{6'd40, 6'd32, 1'b0, 6'd0,  4'h0,    1'b0, 3'd2, 1'b0, 4'h0,  4'h0,    1'b0};
        vecs[4] = '{6'd8,  6'd16, 1'b0, 6'd0,  4'h0,    1'b0, 3'd3, 1'b0, 4'h0,  4'h0,    1'b0};
        vecs[5] = '{6'd63, 6'd62, 1'b0, 6'd0,  4'h0,    1'b0, 3'd4, 1'b0, 4'h0,  4'h0,    1'b0};
        vecs[6] = '{6'd61, 6'd20, 1'b1, 6'd20, 4'h9,    1'b1, 3'd0, 1'b1, 4'h9,  4'h2,    1'b1};
        vecs[7] = '{6'd9,  6'd17, 1'b0, 6'd0,  4'h0,    1'b1, 3'd0, 1'b0, 4'h0,  4'h7,    1'b0};
        vecs[8] = '{6'd8,  6'd0,  1'b1, 6'd8,  4'h1,    1'b1, 3'd0, 1'b1, 4'hA,  PROMO_W, 1'b1};

        rst = 1'b1; move_valid = 1'b0; move_src = '0; move_dst = '0;
        pre_en = 1'b0; pre_pos = '0; pre_code = '0;
        #12;
        check("reset_ready", move_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_turn", turn, 1'b0);
        check("reset_pulses", {done, reject}, 2'b00);
        check("reset_strobes", {wr_place, wr_remove}, 2'b00);
        check("reset_rd_pos", rd_pos, 6'd0);
        check("reset_wr_pos", wr_pos, 6'd0);
        check("reset_wr_code", wr_code, 4'h0);
        check("reset_reject_code", reject_code, 3'd0);
        check("reset_captured", captured, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_move(vecs[i]);

        // Black to move: interrupt a pawn push in PLACE, then replay the opening move.
        reset_during_place(6'd10, 6'd18);
        check("board_reset_src", board[10], 4'h7);
        check("board_reset_dst", board[18], 4'h0);
        run_move(vecs[0]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
